// File: rtl/read_region_strided.sv
// Streams a strided multi-iteration region out of a fifobram read port into a consumer.
// Optional stall-cycle counter is enabled by defining READ_REGION_STALL_CNT_EN.
module read_region_strided #(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned LEN_W      = 14,
    parameter int unsigned ITER_W     = 16,
    parameter int unsigned INFLIGHT_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic              cfg_fifo,
    input  logic [ADDR_W-1:0] cfg_offset,
    input  logic [LEN_W-1:0]  cfg_length,
    input  logic [ITER_W-1:0] cfg_iterations,
    input  logic [ADDR_W-1:0] cfg_stride,
    output logic              busy,
    output logic              op_done,
    output logic              region_re,
    output logic [1:0]        region_rfifobram,
    output logic [ADDR_W-1:0] region_raddr,
    input  logic              region_empty,
    input  logic              region_rvalid,
    input  logic [DATA_W-1:0] region_rdata,
    output logic              out_rvalid,
    output logic [DATA_W-1:0] out_rdata,
    input  logic              out_almostfull,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BRAM_READ = 2'd1,
        FIFO_READ = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  op_done_q;
    logic                  re_q;
    logic [1:0]            rfb_q;
    logic [ADDR_W-1:0]     raddr_q;
    logic                  out_rvalid_q;
    logic [DATA_W-1:0]     out_rdata_q;
    logic [LEN_W-1:0]      len_q;
    logic [ITER_W-1:0]     iters_q;
    logic [ADDR_W-1:0]     stride_q;
    logic [ADDR_W-1:0]     base_q;
    logic [LEN_W-1:0]      line_q;
    logic [ITER_W-1:0]     iter_q;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic [INFLIGHT_W-1:0] inflight_d;

    logic in_read_c;
    logic issue_c;
    logic last_line_c;
    logic last_iter_c;

    assign in_read_c   = (state_q == BRAM_READ) || (state_q == FIFO_READ);
    assign issue_c     = ((state_q == BRAM_READ) && !out_almostfull) ||
                         ((state_q == FIFO_READ) && !out_almostfull && !region_empty);
    assign last_line_c = (line_q == LEN_W'(len_q - LEN_W'(1)));
    assign last_iter_c = (iter_q == ITER_W'(iters_q - ITER_W'(1)));

    // Outstanding reads: a request and a return in the same cycle cancel; never underflow.
    always_comb begin
        inflight_d = inflight_q;
        if (re_q && !region_rvalid) begin
            inflight_d = INFLIGHT_W'(inflight_q + INFLIGHT_W'(1));
        end else if (!re_q && region_rvalid && (inflight_q != '0)) begin
            inflight_d = INFLIGHT_W'(inflight_q - INFLIGHT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            op_done_q    <= 1'b0;
            re_q         <= 1'b0;
            rfb_q        <= 2'b00;
            raddr_q      <= '0;
            out_rvalid_q <= 1'b0;
            out_rdata_q  <= '0;
            len_q        <= '0;
            iters_q      <= '0;
            stride_q     <= '0;
            base_q       <= '0;
            line_q       <= '0;
            iter_q       <= '0;
            inflight_q   <= '0;
        end else begin
            re_q         <= 1'b0;
            op_done_q    <= 1'b0;
            out_rvalid_q <= region_rvalid;
            out_rdata_q  <= region_rdata;
            inflight_q   <= inflight_d;
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        len_q    <= cfg_length;
                        iters_q  <= cfg_iterations;
                        stride_q <= cfg_stride;
                        base_q   <= cfg_offset;
                        line_q   <= '0;
                        iter_q   <= '0;
                        busy_q   <= 1'b1;
                        if ((cfg_length == '0) || (cfg_iterations == '0)) begin
                            state_q <= DRAIN;
                        end else if (cfg_fifo) begin
                            state_q <= FIFO_READ;
                        end else begin
                            state_q <= BRAM_READ;
                        end
                    end
                end
                BRAM_READ, FIFO_READ: begin
                    if (issue_c) begin
                        re_q <= 1'b1;
                        if (state_q == BRAM_READ) begin
                            rfb_q   <= 2'b01;
                            raddr_q <= ADDR_W'(base_q + ADDR_W'(line_q));
                        end else begin
                            rfb_q <= 2'b10;
                        end
                        if (last_line_c) begin
                            line_q <= '0;
                            iter_q <= ITER_W'(iter_q + ITER_W'(1));
                            if (state_q == BRAM_READ) begin
                                base_q <= ADDR_W'(base_q + stride_q);
                            end
                            if (last_iter_c) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            line_q <= LEN_W'(line_q + LEN_W'(1));
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the final request has been issued and all its data returned.
                    if ((inflight_q == '0) && !re_q) begin
                        op_done_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef READ_REGION_STALL_CNT_EN
    logic [31:0] stall_q;

    // Cycles in a read state where a line is pending but the gate blocked the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && op_start) begin
            stall_q <= '0;
        end else if (in_read_c && !issue_c && (stall_q != '1)) begin
            stall_q <= 32'(stall_q + 32'd1);
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_read_c;
    assign unused_read_c = in_read_c;
    assign stall_cycles  = '0;
`endif

    assign busy             = busy_q;
    assign op_done          = op_done_q;
    assign region_re        = re_q;
    assign region_rfifobram = rfb_q;
    assign region_raddr     = raddr_q;
    assign out_rvalid       = out_rvalid_q;
    assign out_rdata        = out_rdata_q;

endmodule

// File: tb/tb_read_region_strided.sv
// Scoreboard bench for read_region_strided with a latency-2 fifobram model.
module tb_read_region_strided;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned LEN_W  = 14;
    localparam int unsigned ITER_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              op_start = 1'b0;
    logic              cfg_fifo = 1'b0;
    logic [ADDR_W-1:0] cfg_offset = '0;
    logic [LEN_W-1:0]  cfg_length = '0;
    logic [ITER_W-1:0] cfg_iterations = '0;
    logic [ADDR_W-1:0] cfg_stride = '0;
    logic              busy, op_done, region_re;
    logic [1:0]        region_rfifobram;
    logic [ADDR_W-1:0] region_raddr;
    logic              region_empty = 1'b0;
    logic              region_rvalid = 1'b0;
    logic [DATA_W-1:0] region_rdata = '0;
    logic              out_rvalid;
    logic [DATA_W-1:0] out_rdata;
    logic              out_almostfull = 1'b0;
    logic [31:0]       stall_cycles;

    read_region_strided dut (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .cfg_fifo(cfg_fifo),
        .cfg_offset(cfg_offset), .cfg_length(cfg_length), .cfg_iterations(cfg_iterations),
        .cfg_stride(cfg_stride), .busy(busy), .op_done(op_done), .region_re(region_re),
        .region_rfifobram(region_rfifobram), .region_raddr(region_raddr),
        .region_empty(region_empty), .region_rvalid(region_rvalid), .region_rdata(region_rdata),
        .out_rvalid(out_rvalid), .out_rdata(out_rdata), .out_almostfull(out_almostfull),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [DATA_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    bit                cur_fifo = 1'b0;
    int                gate_mode = 0;
    int                re_cnt = 0;
    int                done_cnt = 0;
    int                busy_cyc = 0;
    int                fifo_n = 0;
    int                af_timer = 0;
    bit                af_fired = 1'b0;
    logic              gate_af = 1'b0;
    logic              gate_em = 1'b0;
    logic              pv[2];
    logic [DATA_W-1:0] pd[2];

    function automatic logic [DATA_W-1:0] bram_word(input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E3779B1 + 32'h0000_1234;
        return {16{h}};
    endfunction

    function automatic logic [DATA_W-1:0] fifo_word(input int n);
        logic [31:0] h;
        h = (32'(n) * 32'h85EBCA6B) ^ 32'h0000_A5A5;
        return {16{h}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Gate inputs as the DUT sees them at the decision edge.
    always @(posedge clk) begin
        gate_af = out_almostfull;
        gate_em = region_empty;
    end

    // fifobram model, request checker, output scoreboard monitor and gate-input driver.
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        if (!reset_n) begin
            pv[0] = 1'b0; pv[1] = 1'b0;
            region_rvalid = 1'b0;
        end else begin
            region_rvalid = pv[1];
            region_rdata  = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = 1'b0;
            if (busy) busy_cyc++;
            if (region_re) begin
                re_cnt++;
                chk("gate_af", 64'(gate_af), 64'(0));
                if (cur_fifo) begin
                    chk("gate_empty", 64'(gate_em), 64'(0));
                    chk("rfifobram_fifo", 64'(region_rfifobram), 64'(2));
                    d = fifo_word(fifo_n);
                    fifo_n++;
                end else begin
                    chk("rfifobram_bram", 64'(region_rfifobram), 64'(1));
                    if (exp_addr_q.size() == 0) begin
                        chk("extra_re", 64'(1), 64'(0));
                    end else begin
                        chk("raddr", 64'(region_raddr), 64'(exp_addr_q.pop_front()));
                    end
                    d = bram_word(region_raddr);
                end
                pv[0] = 1'b1; pd[0] = d;
            end
            if (out_rvalid) begin
                if (exp_data_q.size() == 0) begin
                    chk("extra_rvalid", 64'(1), 64'(0));
                end else begin
                    d = exp_data_q.pop_front();
                    total++;
                    if (out_rdata !== d) begin
                        bad++;
                        $display("FAIL out_rdata actual=%h required=%h", out_rdata[63:0], d[63:0]);
                    end
                end
            end
            if (op_done) begin
                done_cnt++;
                chk("done_after_data", 64'(exp_data_q.size()), 64'(0));
            end
        end
        case (gate_mode)
            1: begin region_empty = ~region_empty; out_almostfull = 1'b0; end
            2: begin
                if (re_cnt >= 3 && !af_fired) begin af_fired = 1'b1; af_timer = 10; end
                out_almostfull = (af_timer > 0);
                if (af_timer > 0) af_timer--;
                region_empty = 1'b0;
            end
            3: begin
                out_almostfull = ($urandom_range(3) == 0);
                region_empty   = ($urandom_range(2) == 0);
            end
            default: begin out_almostfull = 1'b0; region_empty = 1'b0; end
        endcase
    end

    task automatic start_op(input bit f, input int off, input int len, input int it,
                            input int st, input int mode);
        exp_data_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < it; i++) begin
            for (int l = 0; l < len; l++) begin
                if (f) begin
                    exp_data_q.push_back(fifo_word(fifo_n + i * len + l));
                end else begin
                    exp_addr_q.push_back(ADDR_W'((off + i * st + l) % 16384));
                    exp_data_q.push_back(bram_word(ADDR_W'((off + i * st + l) % 16384)));
                end
            end
        end
        @(negedge clk);
        cur_fifo = f; gate_mode = mode; re_cnt = 0; done_cnt = 0; busy_cyc = 0;
        af_fired = 1'b0; af_timer = 0;
        cfg_fifo = f; cfg_offset = ADDR_W'(off); cfg_length = LEN_W'(len);
        cfg_iterations = ITER_W'(it); cfg_stride = ADDR_W'(st);
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic run_op(input bit f, input int off, input int len, input int it,
                          input int st, input int mode);
        int n;
        start_op(f, off, len, it, st, mode);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", 64'(done_cnt == 0), 64'(0));
        gate_mode = 0;
        repeat (5) @(negedge clk);
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("re_count", 64'(re_cnt), 64'(len * it));
        chk("data_left", 64'(exp_data_q.size()), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(op_done), 64'(0));
        chk("rst_re", 64'(region_re), 64'(0));
        chk("rst_rvalid", 64'(out_rvalid), 64'(0));
        chk("rst_rfb", 64'(region_rfifobram), 64'(0));
        chk("rst_raddr", 64'(region_raddr), 64'(0));
        chk("rst_rdata", 64'(out_rdata[63:0]), 64'(0));
        chk("rst_stall", 64'(stall_cycles), 64'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1'b0, 16, 4, 3, 8, 0);
        chk("stall_no_bp", 64'(stall_cycles), 64'(0));
        run_op(1'b0, 16380, 6, 1, 0, 0);
        run_op(1'b1, 0, 5, 2, 0, 1);
`ifdef READ_REGION_STALL_CNT_EN
        chk("stall_nonzero", 64'(stall_cycles > 0), 64'(1));
`else
        chk("stall_zero", 64'(stall_cycles), 64'(0));
`endif
        run_op(1'b0, 5, 0, 3, 1, 0);
        chk("busy_cycles_len0", 64'(busy_cyc >= 1 && busy_cyc <= 2), 64'(1));
        run_op(1'b1, 5, 4, 0, 1, 0);
        chk("busy_cycles_it0", 64'(busy_cyc >= 1 && busy_cyc <= 2), 64'(1));
        run_op(1'b0, 100, 8, 1, 0, 2);
        run_op(1'b0, 40, 3, 3, 0, 0);
        run_op(1'b0, 40, 3, 3, 3, 0);

        for (int k = 0; k < 6; k++) begin
            run_op(1'(($urandom_range(1))), int'($urandom_range(16383)),
                   int'($urandom_range(10, 1)), int'($urandom_range(4, 1)),
                   int'($urandom_range(16383)), 3);
        end

        // Asynchronous reset in the middle of a BRAM sweep.
        start_op(1'b0, 200, 8, 1, 0, 0);
        for (int n = 0; n < 200 && re_cnt < 3; n++) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_re", 64'(region_re), 64'(0));
        chk("mid_rst_rvalid", 64'(out_rvalid), 64'(0));
        repeat (3) @(negedge clk);
        exp_data_q.delete();
        exp_addr_q.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(1'b0, 200, 8, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/read_region_strided.md
Name: read_region_strided

Overview:
- Parametrised successor of the single-channel region reader.
- Streams a configurable region out of a fifobram (BRAM or FIFO side) into a common-read consumer.
- Adds parametrised widths, a programmable stride between iterations, zero-iteration handling, in-flight tracking, and a busy/op_done handshake.
- Sits between a fifobram read port and an engine's operand input.

Parameters:
DATA_W, 512, width of rdata
ADDR_W, 14, BRAM address and offset width
LEN_W, 14, lines-per-iteration counter width
ITER_W, 16, iteration counter width
INFLIGHT_W, 6, in-flight read counter width; must cover fifobram read latency + 1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
op_start  in  1  start pulse; sampled only in IDLE
cfg_fifo  in  1  1=read FIFO side (rfifobram=10), 0=BRAM side (rfifobram=01)
cfg_offset  in  ADDR_W  first line address (BRAM mode)
cfg_length  in  LEN_W  lines per iteration
cfg_iterations  in  ITER_W  iteration count
cfg_stride  in  ADDR_W  base increment applied after each iteration (BRAM mode)
busy  out  1  high from the cycle after op_start until op_done
op_done  out  1  one-cycle pulse when all requested data is forwarded
region_re  out  1  read enable to fifobram
region_rfifobram  out  2  side select
region_raddr  out  ADDR_W  BRAM read address
region_empty  in  1  FIFO-side empty
region_rvalid  in  1  read data valid
region_rdata  in  DATA_W  read data
out_rvalid  out  1  forwarded valid
out_rdata  out  DATA_W  forwarded data
out_almostfull  in  1  consumer backpressure; consumer asserts it with slack >= fifobram latency + 2
stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async, reset_n=0): state IDLE; all counters 0; busy, op_done, region_re, out_rvalid = 0; region_rfifobram=00; region_raddr=0; out_rdata=0. In-flight data is discarded.
- Registered outputs: out_rvalid/out_rdata = region_rvalid/region_rdata delayed by 1 cycle, every cycle, in all states.
- region_re defaults to 0 each cycle. It is a registered output: a request is decided in cycle t and region_re is high in cycle t+1.
- IDLE:
  - On op_start, latch all cfg_* fields; base=cfg_offset; line=0; iter=0; busy<=1.
  - If cfg_length==0 or cfg_iterations==0: go to DRAIN (no requests; op_done follows).
  - Else if cfg_fifo: go to FIFO_READ.
  - Else: go to BRAM_READ.
  - op_start outside IDLE is ignored.
- BRAM_READ: issue when !out_almostfull.
  - region_re<=1, rfifobram<=01, raddr<=base+line (mod 2^ADDR_W), line++.
  - On line==length-1: line<=0, iter++, base<=base+stride (mod 2^ADDR_W).
  - If iter==iterations-1: go to DRAIN.
- FIFO_READ: issue when !out_almostfull && !region_empty.
  - region_re<=1, rfifobram<=10; raddr holds its value.
  - Same line/iter counting as BRAM_READ; stride ignored.
- In-flight counter:
  - +1 per region_re, -1 per region_rvalid; both in the same cycle leaves it unchanged.
  - rvalid with counter 0 does not decrement (saturates at 0).
- DRAIN:
  - When inflight==0 and region_re==0: op_done<=1 for one cycle, busy<=0, go to IDLE.
  - op_done is coincident with or after the cycle carrying the last out_rvalid.
- Stride 0: re-reads the same window each iteration. Stride==length: contiguous sweep.
- Stall rule: requests stop at most 1 cycle after out_almostfull rises; no request is issued in a cycle where the gating input is sampled high.

Optional Feature:
- Macro READ_REGION_STALL_CNT_EN.
- Defined: stall_cycles counts cycles spent in BRAM_READ/FIFO_READ where a line remains but no request issues (almostfull, or empty in FIFO mode).
  - Cleared on op_start; saturates at 2^32-1; holds after op_done.
- Undefined: stall_cycles tied to 0 and no counter logic is synthesised.

Test Plan:
- BRAM, offset=16, length=4, iterations=3, stride=8, no backpressure -> raddr sequence 16,17,18,19,24,25,26,27,32,33,34,35; 12 out_rvalid; one op_done after the last rvalid.
- BRAM, offset=16380, length=6, iterations=1 -> raddr 16380..16383 then 0,1 (ADDR_W wrap); op_done once.
- FIFO, length=5, iterations=2; region_empty toggled every other cycle -> exactly 10 region_re, rfifobram=10, none while empty sampled high; stall_cycles>0 with macro, 0 without.
- length=0 or iterations=0 -> no region_re; busy high for 1-2 cycles; single op_done pulse.
- BRAM length=8; out_almostfull held high for 10 cycles mid-stream -> at most 1 further region_re after the rise; resumes in order; all 8 lines delivered.
- reset_n low mid-BRAM_READ (line 3 of 8) -> busy/region_re/out_rvalid immediately 0; after release, a new op_start runs cleanly from offset.
